// File: rtl/compare_sched_pkg.sv
// compare_sched_pkg: shared types and field layout for the compare sequencer.
// Threshold word: [23] plus sign, [22:12] plus value, [11] minus sign, [10:0] minus value.
package compare_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LSET,
        LPULSE,
        FEED,
        WAIT,
        CAP,
        OUT
    } state_t;

    localparam int THR_W    = 24;
    localparam int WIN_W    = 63;
    localparam int SAMPLE_W = 9;
    localparam int N_SAMPLE = WIN_W / SAMPLE_W;

    localparam int THR_PSGN    = 23;
    localparam int THR_PVAL_HI = 22;
    localparam int THR_PVAL_LO = 12;
    localparam int THR_MSGN    = 11;
    localparam int THR_MVAL_HI = 10;
    localparam int THR_MVAL_LO = 0;

endpackage

// File: rtl/compare_sched.sv
// compare_sched: time-shares one threshold compare block across NUM_CH channels.
// Optional stall counter output enabled by COMPARE_SCHED_STALL_CNT_EN.
module compare_sched
    import compare_sched_pkg::*;
#(
    parameter int NUM_CH  = 32,
    parameter int ADDR_W  = 5,
    parameter int CMP_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
`ifdef COMPARE_SCHED_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              thr_rd_en,
    output logic [ADDR_W-1:0] thr_rd_addr,
    input  logic [THR_W-1:0]  thr_rd_data,
    input  logic              win_valid,
    output logic              win_ready,
    input  logic [WIN_W-1:0]  win_data,
    output logic [WIN_W-1:0]  cmp_data,
    output logic [THR_W-1:0]  cmp_thr,
    output logic              cmp_loadthr,
    input  logic              cmp_binary,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [NUM_CH-1:0] res_data
);

    localparam int WC_W = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] ch;
    logic [WC_W-1:0]   wait_cnt;
    logic              win_hs;
    logic              res_hs;
    logic              last_ch;
    logic              wait_end;

    assign win_hs      = win_valid && win_ready;
    assign res_hs      = res_valid && res_ready;
    assign last_ch     = (ch == ADDR_W'(NUM_CH - 1));
    assign wait_end    = (wait_cnt == WC_W'(CMP_LAT - 1));
    assign thr_rd_addr = ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = FETCH;
            FETCH:   state_n = LSET;
            LSET:    state_n = LPULSE;
            LPULSE:  state_n = FEED;
            FEED:    if (win_hs) state_n = WAIT;
            WAIT:    if (wait_end) state_n = CAP;
            CAP:     state_n = last_ch ? OUT : FETCH;
            OUT:     if (res_hs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes decode the next state so every output comes straight off a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            thr_rd_en   <= 1'b0;
            cmp_loadthr <= 1'b0;
            win_ready   <= 1'b0;
            res_valid   <= 1'b0;
        end else begin
            busy        <= (state_n != IDLE);
            done        <= (state == OUT) && res_hs;
            thr_rd_en   <= (state_n == FETCH);
            cmp_loadthr <= (state_n == LPULSE);
            win_ready   <= (state_n == FEED);
            res_valid   <= (state_n == OUT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch       <= '0;
            wait_cnt <= '0;
            cmp_data <= '0;
            cmp_thr  <= '0;
            res_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ch       <= '0;
                        res_data <= '0;
                    end
                end
                LSET: cmp_thr <= thr_rd_data;
                FEED: begin
                    if (win_hs) begin
                        cmp_data <= win_data;
                        wait_cnt <= '0;
                    end
                end
                WAIT: wait_cnt <= wait_cnt + 1'b1;
                CAP: begin
                    res_data[ch] <= cmp_binary;
                    if (!last_ch) ch <= ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef COMPARE_SCHED_STALL_CNT_EN
    logic stall_inc;

    assign stall_inc = ((state == FEED) && !win_valid) ||
                       ((state == OUT) && !res_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if (stall_inc && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_compare_sched.sv
// tb_compare_sched: scoreboard bench for compare_sched with a model compare block.
// Model: binary = (2*max(samples) < signed plus threshold).
module tb_compare_sched;

    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 2;
    localparam int CMP_LAT = 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic              thr_rd_en;
    logic [ADDR_W-1:0] thr_rd_addr;
    logic [23:0]       thr_rd_data;
    logic              win_valid;
    logic              win_ready;
    logic [62:0]       win_data;
    logic [62:0]       cmp_data;
    logic [23:0]       cmp_thr;
    logic              cmp_loadthr;
    logic              cmp_binary;
    logic              res_valid;
    logic              res_ready;
    logic [NUM_CH-1:0] res_data;
`ifdef COMPARE_SCHED_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    compare_sched #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .CMP_LAT(CMP_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
`ifdef COMPARE_SCHED_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .thr_rd_en  (thr_rd_en),
        .thr_rd_addr(thr_rd_addr),
        .thr_rd_data(thr_rd_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .cmp_data   (cmp_data),
        .cmp_thr    (cmp_thr),
        .cmp_loadthr(cmp_loadthr),
        .cmp_binary (cmp_binary),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
    );

    int total = 0;
    int bad   = 0;

    logic [23:0]       thr_mem [NUM_CH];
    logic [62:0]       wins    [NUM_CH];
    logic [NUM_CH-1:0] sb[$];

    int idx;
    int pending;
    int stall_ch;
    int stall_left;
    int stall_on;
    logic [62:0] stall_ref;

    int done_seen = 0;
    int done_base = 0;
    int exp_addr  = 0;
    int load_cnt  = 0;

    logic [23:0] thr_l = '0;
    logic        s1    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out", nm);
    endtask

    function automatic logic cmp_model(logic [62:0] w, logic [23:0] t);
        int mx;
        int s;
        int tp;
        logic [8:0] f;
        mx = -1000;
        for (int i = 0; i < 7; i++) begin
            f = w[i*9 +: 9];
            s = int'($signed(f));
            if (s > mx) mx = s;
        end
        tp = int'(t[22:12]);
        if (t[23]) tp = -tp;
        return (2 * mx < tp);
    endfunction

    function automatic logic [62:0] mk_win(int m, int rot);
        logic [62:0] w;
        logic [8:0]  s;
        w = '0;
        for (int i = 0; i < 7; i++) begin
            s = 9'(m - 3 * ((i + rot) % 7));
            w[i*9 +: 9] = s;
        end
        return w;
    endfunction

    // Threshold SRAM: one-cycle read latency.
    always @(posedge clk)
        if (thr_rd_en) thr_rd_data <= thr_mem[thr_rd_addr];

    // Compare block: latches threshold on strobe rising edge, CMP_LAT pipeline.
    always @(posedge cmp_loadthr) thr_l = cmp_thr;

    always @(posedge clk) begin
        s1         <= cmp_model(cmp_data, thr_l);
        cmp_binary <= s1;
    end

    // Window feeder, driven at the falling edge.
    initial begin
        win_valid = 1'b0;
        win_data  = '0;
        forever begin
            @(negedge clk);
            if (pending != 0) begin
                idx++;
                pending = 0;
            end
            if (stall_left > 0 && idx == stall_ch &&
                (win_ready || stall_on != 0)) begin
                if (stall_on == 0) begin
                    stall_on  = 1;
                    stall_ref = cmp_data;
                end else begin
                    chk("stall_win_ready", 64'(win_ready), 64'd1);
                    chk("stall_cmp_data", 64'(cmp_data), 64'(stall_ref));
                end
                win_valid = 1'b0;
                stall_left--;
            end else begin
                stall_on  = 0;
                win_valid = (idx < NUM_CH);
                if (idx < NUM_CH) win_data = wins[idx];
            end
            pending = (win_valid && win_ready) ? 1 : 0;
        end
    end

    // Monitor: scoreboard pop, output stability, strobe protocol.
    initial begin
        logic              hs_prev;
        logic              val_prev;
        logic              load_prev;
        logic [NUM_CH-1:0] data_prev;
        logic [23:0]       thr_strobe;
        hs_prev    = 1'b0;
        val_prev   = 1'b0;
        load_prev  = 1'b0;
        data_prev  = '0;
        thr_strobe = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hs_prev   = 1'b0;
                val_prev  = 1'b0;
                load_prev = 1'b0;
            end else begin
                chk("done_vs_hs", 64'(done), 64'(hs_prev));
                if (done) done_seen++;
                if (hs_prev) begin
                    chk("res_valid_drop", 64'(res_valid), 64'd0);
                end else if (val_prev) begin
                    chk("res_valid_hold", 64'(res_valid), 64'd1);
                    chk("res_data_hold", 64'(res_data), 64'(data_prev));
                end
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL res_unexpected: got %0h want none",
                                 res_data);
                    end else begin
                        chk("res_data", 64'(res_data), 64'(sb.pop_front()));
                    end
                end
                hs_prev   = res_valid && res_ready;
                val_prev  = res_valid;
                data_prev = res_data;
                if (cmp_loadthr) begin
                    chk("load_width", 64'(load_prev), 64'd0);
                    load_cnt++;
                    thr_strobe = cmp_thr;
                    chk("strobe_thr", 64'(cmp_thr),
                        64'(thr_mem[thr_rd_addr]));
                end else if (load_prev) begin
                    chk("thr_after_strobe", 64'(cmp_thr), 64'(thr_strobe));
                end
                load_prev = cmp_loadthr;
                if (thr_rd_en) begin
                    chk("thr_rd_addr", 64'(thr_rd_addr), 64'(exp_addr));
                    exp_addr++;
                end
            end
        end
    end

    task automatic setup(input logic [23:0] t0, input logic [23:0] t1,
                         input logic [23:0] t2, input logic [23:0] t3,
                         input int m0, input int m1, input int m2, input int m3);
        thr_mem[0] = t0;
        thr_mem[1] = t1;
        thr_mem[2] = t2;
        thr_mem[3] = t3;
        wins[0]    = mk_win(m0, 0);
        wins[1]    = mk_win(m1, 2);
        wins[2]    = mk_win(m2, 4);
        wins[3]    = mk_win(m3, 6);
        idx        = 0;
        pending    = 0;
        stall_on   = 0;
    endtask

    task automatic run_start(input logic [NUM_CH-1:0] exp);
        sb.push_back(exp);
        exp_addr  = 0;
        load_cnt  = 0;
        done_base = done_seen;
        start     = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while (done_seen == done_base && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_seen == done_base) begin
            timeout(nm);
        end else begin
            chk("addr_count", 64'(exp_addr), 64'(NUM_CH));
            chk("load_count", 64'(load_cnt), 64'(NUM_CH));
            chk("busy_after_done", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        res_ready  = 1'b1;
        stall_ch   = -1;
        stall_left = 0;
        setup(24'h0, 24'h0, 24'h0, 24'h0, 0, 0, 0, 0);
        idx = NUM_CH;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctl", 64'({busy, done, thr_rd_en, thr_rd_addr, win_ready,
                            cmp_loadthr, res_valid, res_data}), 64'd0);
        chk("rst_cmp_data", 64'(cmp_data), 64'd0);
        chk("rst_cmp_thr", 64'(cmp_thr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Pass A: basic 0110, 10-cycle window stall on ch1.
        setup(24'h064064, 24'h064064, 24'h064064, 24'h064064, 60, 40, -10, 55);
        stall_ch   = 1;
        stall_left = 10;
        run_start(4'b0110);
        wait_done("done_pass_a", 400);
`ifdef COMPARE_SCHED_STALL_CNT_EN
        chk("stall_cnt_a", 64'(stall_cnt), 64'd10);
`endif
        chk("stall_consumed", 64'(stall_left), 64'd0);

        // Pass B: mixed thresholds, downstream not ready for 5 OUT cycles.
        stall_ch = -1;
        setup(24'h0C8000, 24'h832000, 24'h000000, 24'h01E000, 90, -30, 0, 14);
        res_ready = 1'b0;
        run_start(4'b1011);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!res_valid) timeout("res_valid_b");
        repeat (5) @(negedge clk);
        #1;
        chk("res_valid_stalled", 64'(res_valid), 64'd1);
        chk("no_done_stalled", 64'(done_seen - done_base), 64'd0);
        res_ready = 1'b1;
        wait_done("done_pass_b", 50);
`ifdef COMPARE_SCHED_STALL_CNT_EN
        chk("stall_cnt_b", 64'(stall_cnt), 64'd5);
`endif

        // Pass C: reset during the first WAIT cycle of ch2.
        setup(24'h064064, 24'h064064, 24'h064064, 24'h064064, 60, 40, -10, 55);
        run_start(4'b0110);
        n = 0;
        while (!(thr_rd_en && thr_rd_addr == 2'd2) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!(thr_rd_en && thr_rd_addr == 2'd2)) timeout("fetch_ch2");
        repeat (4) @(negedge clk);
        #1;
        chk("wait_state_ctl", 64'({win_ready, cmp_loadthr, busy}), 64'b001);
        rst_n = 1'b0;
        #1;
        chk("abort_ctl", 64'({busy, done, thr_rd_en, thr_rd_addr, win_ready,
                              cmp_loadthr, res_valid, res_data}), 64'd0);
        chk("abort_cmp_data", 64'(cmp_data), 64'd0);
        chk("abort_cmp_thr", 64'(cmp_thr), 64'd0);
        sb.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Pass D: fresh pass with a start pulse during FEED.
        setup(24'h064064, 24'h064064, 24'h064064, 24'h064064, 49, 50, -100, 0);
        run_start(4'b1101);
        n = 0;
        while (!win_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!win_ready) timeout("feed_d");
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        chk("busy_ignored_start", 64'(busy), 64'd1);
        wait_done("done_pass_d", 400);
        repeat (20) @(negedge clk);
        #1;
        chk("done_count", 64'(done_seen), 64'd3);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/compare_sched.md
Name: compare_sched

Overview:
- Sequencer that time-shares one 7-input max-pool/threshold compare block across NUM_CH output channels of a binarized layer.
- Per channel it:
  - fetches the packed 24-bit threshold from threshold SRAM,
  - issues a clean single-cycle threshold-load strobe,
  - accepts one 63-bit window from the upstream feature buffer,
  - waits out the compare pipeline and captures the binary result.
- After NUM_CH channels it emits one packed result word downstream with valid/ready.

Parameters:
- NUM_CH, 32, channels per result word; also the width of res_data.
- ADDR_W, 5, threshold SRAM address width; must satisfy 2**ADDR_W >= NUM_CH.
- CMP_LAT, 2, clock cycles from cmp_data change to a valid cmp_binary.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a pass over channels 0..NUM_CH-1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse on the res_valid&res_ready handshake
- thr_rd_en  out  1  threshold SRAM read enable
- thr_rd_addr  out  ADDR_W  threshold address (= current channel)
- thr_rd_data  in  24  threshold word, valid 1 cycle after thr_rd_en
- win_valid  in  1  upstream window valid
- win_ready  out  1  high only in state FEED
- win_data  in  63  seven signed 9-bit samples
- cmp_data  out  63  registered window to compare block
- cmp_thr  out  24  registered threshold to compare block
- cmp_loadthr  out  1  threshold-load strobe (compare block latches on its rising edge)
- cmp_binary  in  1  compare block result
- res_valid  out  1  result word valid
- res_ready  in  1  downstream ready
- res_data  out  NUM_CH  bit ch = binary result of channel ch

Behaviour:
- Reset values:
  - all outputs 0, FSM in IDLE, channel counter 0.
  - rst_n low mid-operation aborts the pass immediately with the same values. No partial result is emitted.
- All outputs are registered. cmp_loadthr must be a flop output so it is glitch-free.
- FSM states and transitions:
  - IDLE: start=1 → clear res_data, ch=0 → FETCH. start while busy is ignored.
  - FETCH (1 cycle): thr_rd_en=1, thr_rd_addr=ch → LSET.
  - LSET (1 cycle): cmp_thr <= thr_rd_data → LPULSE.
  - LPULSE (1 cycle): cmp_loadthr=1 with cmp_thr stable → FEED. cmp_loadthr returns to 0 on exit.
  - FEED: win_ready=1. On win_valid&win_ready, cmp_data <= win_data and wait counter=0 → WAIT. Stalls indefinitely if win_valid=0.
  - WAIT: count CMP_LAT cycles, then → CAP.
  - CAP (1 cycle): res_data[ch] <= cmp_binary.
    - If ch==NUM_CH-1 → OUT.
    - Else ch <= ch+1 → FETCH.
  - OUT: res_valid=1 with res_data held stable until res_ready. On handshake: res_valid <= 0, done pulse, → IDLE.
- Per-channel latency with no stalls: 4 + CMP_LAT + 1 = 7 cycles at default.
- cmp_thr holds between loads. cmp_loadthr is never high for two consecutive cycles.
- Channel counter has no wrap-around: the pass terminates at NUM_CH-1.
- res_ready may be high before res_valid. Handshake completes in the first OUT cycle.
- busy is 1 in every state except IDLE.

Optional Feature:
- Macro: COMPARE_SCHED_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0], a saturating counter (sticks at 0xFFFF).
  - Counts cycles in FEED with win_valid=0 plus cycles in OUT with res_ready=0.
  - Cleared on start and on reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package compare_sched_pkg holds:
  - state enum encoding: IDLE, FETCH, LSET, LPULSE, FEED, WAIT, CAP, OUT.
  - THR_W=24, WIN_W=63, SAMPLE_W=9.
  - threshold field positions: [23] plus sign, [22:12] plus value, [11] minus sign, [10:0] minus value.
- No sub-module. A single FSM module is natural; the compare block is instantiated beside it at the top level.

Test Plan:
- NUM_CH=4; thresholds ch0..3 = 0x064064; windows with max 60, 40, -10, 55 → compare model yields 0,1,1,0 → res_data=4'b0110, res_valid for one cycle, done pulse.
- win_valid held low 10 cycles in FEED of ch1 → no cmp_data change, win_ready stays 1; with macro, stall_cnt=10.
- res_ready low 5 cycles in OUT → res_valid and res_data stable for 5 cycles, done only on the handshake cycle.
- rst_n asserted during WAIT of ch2 → all outputs 0 next cycle. A fresh start completes a full pass with correct bits.
- start pulsed during FEED → ignored: ch sequence unchanged, exactly one done.
- Protocol checker on every pass:
  - cmp_loadthr is exactly 1 cycle wide, once per channel.
  - cmp_thr is stable during the strobe cycle and the cycle after.
  - thr_rd_addr equals 0,1,2,3 in order.
